grant_burst_xfer: RTL and testbench

GRANT_BURST_XFER -- requirements
Module: grant_burst_xfer

---
 rtl/grant_burst_xfer_if.sv | 36 +++
 rtl/grant_burst_xfer.sv | 99 +++++++++
 tb/tb_grant_burst_xfer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/grant_burst_xfer_if.sv
// Bundle of the source request/grant lines, source data and the shared sink port
// used by grant_burst_xfer.
interface grant_burst_xfer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
);
  logic              req_0;
  logic              req_1;
  logic              gnt_0;
  logic              gnt_1;
  logic [LEN_W-1:0]  len_0;
  logic [LEN_W-1:0]  len_1;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_owner;
  logic              rd_0;
  logic              rd_1;
  logic              done_0;
  logic              done_1;
  logic              busy;

  // Burst engine side.
  modport slave (
    input  req_0, req_1, gnt_0, gnt_1, len_0, len_1, data_0, data_1, out_ready,
    output out_data, out_valid, out_owner, rd_0, rd_1, done_0, done_1, busy
  );

  // Sources, arbiter and sink side.
  modport master (
    output req_0, req_1, gnt_0, gnt_1, len_0, len_1, data_0, data_1, out_ready,
    input  out_data, out_valid, out_owner, rd_0, rd_1, done_0, done_1, busy
  );
endinterface

// File: rtl/grant_burst_xfer.sv
// Moves a granted burst of words from one of two sources to a shared sink,
// popping the owning source once per accepted beat and pulsing done at the end.
module grant_burst_xfer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input logic                clock,
  input logic                reset,
  grant_burst_xfer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q;
  logic              owner_q;
  logic [LEN_W-1:0]  count_q;
  logic              valid_q;
  logic              busy_q;
  logic [1:0]        done_q;

  logic              take_0;
  logic              take_1;
  logic              start;
  logic              start_owner;
  logic [LEN_W-1:0]  start_len;
  logic              beat;
  logic [DATA_W-1:0] mux_data;

  always_comb begin
    take_0      = bus.gnt_0 & bus.req_0;
    take_1      = bus.gnt_1 & bus.req_1;
    start       = take_0 | take_1;
    // Source 0 wins if both look granted.
    start_owner = ~take_0;
    start_len   = take_0 ? bus.len_0 : bus.len_1;
    beat        = valid_q & bus.out_ready;
    mux_data    = owner_q ? bus.data_1 : bus.data_0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            owner_q <= start_owner;
            count_q <= start_len;
            busy_q  <= 1'b1;
            if (start_len != '0) begin
              state_q <= StXfer;
              valid_q <= 1'b1;
            end else begin
              // Zero-length burst skips straight to the completion pulse.
              state_q <= StDone;
              done_q  <= start_owner ? 2'b10 : 2'b01;
            end
          end
        end
        StXfer: begin
          if (beat) begin
            count_q <= count_q - LEN_W'(1);
            if (count_q == LEN_W'(1)) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= owner_q ? 2'b10 : 2'b01;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 2'b00;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 2'b00;
        end
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_owner = owner_q;
  assign bus.out_data  = valid_q ? mux_data : '0;
  assign bus.rd_0      = beat & ~owner_q;
  assign bus.rd_1      = beat & owner_q;
  assign bus.done_0    = done_q[0];
  assign bus.done_1    = done_q[1];
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_grant_burst_xfer.sv
// Directed bench for grant_burst_xfer: expected words are queued when a burst is
// armed and popped/compared whenever the DUT pops a source.
module tb_grant_burst_xfer;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  grant_burst_xfer_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  grant_burst_xfer #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request/grant source s with length len and queue the words it will supply.
  task automatic arm(input int s, input int len);
    logic [DW-1:0] w;
    if (s == 0) begin
      bus.req_0 = 1'b1; bus.gnt_0 = 1'b1; bus.len_0 = LW'(len); w = bus.data_0;
    end else begin
      bus.req_1 = 1'b1; bus.gnt_1 = 1'b1; bus.len_1 = LW'(len); w = bus.data_1;
    end
    for (int k = 0; k < len; k++) begin
      sb.push_back(w);
      w = w + 1'b1;
    end
  endtask

  task automatic drop(input int s);
    if (s == 0) begin bus.req_0 = 1'b0; bus.gnt_0 = 1'b0; end
    else begin bus.req_1 = 1'b0; bus.gnt_1 = 1'b0; end
  endtask

  // Called at posedge+1 of the idle cycle preceding the start edge. Returns at
  // posedge+1 of the idle cycle after done, with the owner's request dropped.
  task automatic run_xfer(input int own, input int nb, input logic [15:0] rpat,
                          input int exp_cycles);
    int beats = 0;
    int cyc = 0;
    bit seen_done = 0;
    bit stalled = 0;
    bit popped;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] exp_w;
    logic rd_own, rd_oth, dn_own, dn_oth;
    @(negedge clock);
    check("idle_busy", bus.busy, 0);
    check("idle_done", {bus.done_1, bus.done_0}, 0);
    @(posedge clock); #1;
    while (!seen_done && cyc < 40) begin
      bus.out_ready = (cyc < 16) ? rpat[cyc] : 1'b1;
      popped = 0;
      @(negedge clock);
      rd_own = own ? bus.rd_1 : bus.rd_0;
      rd_oth = own ? bus.rd_0 : bus.rd_1;
      dn_own = own ? bus.done_1 : bus.done_0;
      dn_oth = own ? bus.done_0 : bus.done_1;
      if (cyc == 0) check("first_valid", bus.out_valid, (nb != 0));
      check("busy", bus.busy, 1);
      check("owner", bus.out_owner, own);
      check("rd_other", rd_oth, 0);
      if (bus.out_valid) begin
        check("rd_owner", rd_own, bus.out_ready);
        check("done_in_xfer", {dn_own, dn_oth}, 0);
        if (stalled) check("stall_data", bus.out_data, held);
        if (bus.out_ready) begin
          if (sb.size() == 0) check("sb_underflow", 1, 0);
          else begin
            exp_w = sb.pop_front();
            check("beat_data", bus.out_data, exp_w);
          end
          beats++;
          popped = 1;
          stalled = 0;
        end else begin
          held = bus.out_data;
          stalled = 1;
        end
      end else begin
        check("done_owner", dn_own, 1);
        check("done_other", dn_oth, 0);
        check("done_data", bus.out_data, 0);
        check("done_rd", rd_own, 0);
        seen_done = 1;
      end
      cyc++;
      @(posedge clock); #1;
      if (popped) begin
        if (own == 0) bus.data_0 = bus.data_0 + 1'b1;
        else bus.data_1 = bus.data_1 + 1'b1;
      end
    end
    check("done_seen", seen_done, 1);
    check("beat_count", beats, nb);
    check("burst_cycles", cyc, exp_cycles);
    drop(own);
  endtask

  initial begin
    logic [DW-1:0] exp_w;
    reset = 1'b1;
    bus.req_0 = 0; bus.req_1 = 0; bus.gnt_0 = 0; bus.gnt_1 = 0;
    bus.len_0 = '0; bus.len_1 = '0;
    bus.data_0 = 8'h10; bus.data_1 = 8'hA0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_rd", {bus.rd_1, bus.rd_0}, 0);
    check("rst_done", {bus.done_1, bus.done_0}, 0);
    check("rst_owner", bus.out_owner, 0);
    check("rst_data", bus.out_data, 0);

    // Basic 3-beat burst starting on the first edge out of reset.
    @(posedge clock); #1;
    reset = 1'b0;
    arm(0, 3);
    run_xfer(0, 3, 16'hFFFF, 4);

    // Back-to-back with ready pattern 1,0,0,1,1.
    arm(0, 3);
    run_xfer(0, 3, 16'hFFF9, 6);

    // Both granted: source 0 wins.
    arm(0, 2);
    bus.req_1 = 1'b1; bus.gnt_1 = 1'b1; bus.len_1 = LW'(5);
    run_xfer(0, 2, 16'hFFFF, 3);
    drop(1);

    // Zero-length burst on source 1.
    arm(1, 0);
    run_xfer(1, 0, 16'hFFFF, 1);

    // Reset after the second of four beats.
    arm(0, 4);
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("rst_burst_idle", bus.busy, 0);
    @(posedge clock); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst_burst_rd", bus.rd_0, 1);
      exp_w = sb.pop_front();
      check("rst_burst_data", bus.out_data, exp_w);
      @(posedge clock); #1;
      bus.data_0 = bus.data_0 + 1'b1;
    end
    reset = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_rd", {bus.rd_1, bus.rd_0}, 0);
    check("abort_done", {bus.done_1, bus.done_0}, 0);
    check("abort_data", bus.out_data, 0);
    check("abort_owner", bus.out_owner, 0);
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    arm(0, 4);
    run_xfer(0, 4, 16'hFFFF, 5);

    // Grant hand-over to source 1 while it has been requesting all along.
    arm(0, 2);
    bus.req_1 = 1'b1; bus.len_1 = LW'(3);
    run_xfer(0, 2, 16'hFFFF, 3);
    arm(1, 3);
    run_xfer(1, 3, 16'hFFFF, 4);

    @(negedge clock);
    check("final_idle", bus.busy, 0);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
